// File: rtl/npc_bp_pkg.sv
// Shared types for the next-PC predictor: counter encodings, BTB entry
// layout and index-width helper. Saturating counters exist only with NPC_BHT_EN.
package npc_bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam cnt_e CNT_ALLOC = WT;

    // Tag and target fields are sized for RV32 PCs.
    localparam int BTB_FIELD_W = 32;

    typedef struct packed {
        logic                   valid;
        logic [BTB_FIELD_W-1:0] tag;
        logic [BTB_FIELD_W-1:0] target;
`ifdef NPC_BHT_EN
        cnt_e                   cnt;
`endif
    } btb_entry_t;

    function automatic int btb_idx_w(input int entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/npc_predictor_btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (fetch, EX),
// one synchronous write port, whole table cleared by async reset.
module btb_table
    import npc_bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX     = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IDX-1:0] rd_f_idx,
    output btb_entry_t     rd_f,
    input  logic [IDX-1:0] rd_e_idx,
    output btb_entry_t     rd_e,
    input  logic           wr_en,
    input  logic [IDX-1:0] wr_idx,
    input  btb_entry_t     wr_ent
);

    btb_entry_t mem_q [ENTRIES];

    // Table storage; reset drops any pending write and invalidates all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_ent;
        end
    end

    // Read ports see the pre-update contents during a write cycle.
    always_comb begin
        rd_f = mem_q[rd_f_idx];
        rd_e = mem_q[rd_e_idx];
    end

endmodule

// File: rtl/npc_predictor.sv
// Next-PC stage: PC register, BTB lookup, EX mispredict redirect and flushes.
// Optional macro NPC_BHT_EN adds 2-bit saturating counters per BTB entry.
module npc_predictor
    import npc_bp_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            CPU_CLK,
    input  logic            CPU_RST_N,
    input  logic            StallF,
    input  logic            JalD,
    input  logic [XLEN-1:0] JalTarget,
    input  logic            JalrE,
    input  logic [XLEN-1:0] JalrTarget,
    input  logic            BranchValidE,
    input  logic            BranchE,
    input  logic [XLEN-1:0] BranchTarget,
    input  logic [XLEN-1:0] PCE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    output logic            FlushD,
    output logic            FlushE
);

    localparam int IDX = btb_idx_w(BTB_ENTRIES);

    logic [XLEN-1:0]        pcf_q, pcf_d;
    logic [XLEN-1:0]        pcf_plus4, ex_target;
    logic [IDX-1:0]         f_idx, e_idx;
    logic [BTB_FIELD_W-1:0] f_tag, e_tag;
    btb_entry_t             f_ent, e_ent, wr_ent;
    logic                   f_hit, e_hit, misp_e, wr_en;

    assign f_idx = pcf_q[IDX+1:2];
    assign f_tag = BTB_FIELD_W'(pcf_q[XLEN-1:IDX+2]);
    assign e_idx = PCE[IDX+1:2];
    assign e_tag = BTB_FIELD_W'(PCE[XLEN-1:IDX+2]);
    assign PCF   = pcf_q;

    btb_table #(
        .ENTRIES (BTB_ENTRIES),
        .IDX     (IDX)
    ) u_btb (
        .clk      (CPU_CLK),
        .rst_n    (CPU_RST_N),
        .rd_f_idx (f_idx),
        .rd_f     (f_ent),
        .rd_e_idx (e_idx),
        .rd_e     (e_ent),
        .wr_en    (wr_en),
        .wr_idx   (e_idx),
        .wr_ent   (wr_ent)
    );

    // Fetch-side lookup: hit, prediction and predicted target for PCF.
    always_comb begin
        pcf_plus4 = pcf_q + XLEN'(4);
        f_hit     = f_ent.valid && (f_ent.tag == f_tag);
        e_hit     = e_ent.valid && (e_ent.tag == e_tag);
`ifdef NPC_BHT_EN
        PredTakenF = f_hit && f_ent.cnt[1];
`else
        PredTakenF = f_hit;
`endif
        PredTargetF = f_hit ? XLEN'(f_ent.target) : pcf_plus4;
    end

    // Mispredict detection, flushes and next-PC priority mux.
    always_comb begin
        misp_e = JalrE
              || (BranchValidE && (BranchE != PredTakenE))
              || (BranchValidE && BranchE && PredTakenE
                  && (BranchTarget != PredTargetE));
        if (JalrE)        ex_target = JalrTarget;
        else if (BranchE) ex_target = BranchTarget;
        else              ex_target = PCE + XLEN'(4);
        FlushE = misp_e;
        FlushD = misp_e || JalD;
        if (misp_e)          pcf_d = ex_target;
        else if (JalD)       pcf_d = JalTarget;
        else if (StallF)     pcf_d = pcf_q;
        else if (PredTakenF) pcf_d = PredTargetF;
        else                 pcf_d = pcf_plus4;
    end

    // BTB training from conditional branches resolved in EX.
    always_comb begin
        wr_en  = 1'b0;
        wr_ent = e_ent;
        if (BranchValidE) begin
            if (BranchE) begin
                wr_en         = 1'b1;
                wr_ent.valid  = 1'b1;
                wr_ent.tag    = e_tag;
                wr_ent.target = BTB_FIELD_W'(BranchTarget);
`ifdef NPC_BHT_EN
                if (!e_hit)             wr_ent.cnt = CNT_ALLOC;
                else if (e_ent.cnt != ST) wr_ent.cnt = cnt_e'(e_ent.cnt + 2'd1);
`endif
            end else if (e_hit) begin
                wr_en = 1'b1;
`ifdef NPC_BHT_EN
                if (e_ent.cnt != SNT) wr_ent.cnt = cnt_e'(e_ent.cnt - 2'd1);
`else
                wr_ent.valid = 1'b0;
`endif
            end
        end
    end

    // Fetch PC register.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) pcf_q <= RESET_PC;
        else            pcf_q <= pcf_d;
    end

endmodule

// File: tb/tb_npc_predictor.sv
// Directed testbench for npc_predictor with hand-computed expectations.
// Covers reset, BTB learning, hysteresis, priority, aliasing and wrap.
module tb_npc_predictor;

    logic        CPU_CLK, CPU_RST_N;
    logic        StallF, JalD, JalrE, BranchValidE, BranchE, PredTakenE;
    logic [31:0] JalTarget, JalrTarget, BranchTarget, PCE, PredTargetE;
    logic [31:0] PCF, PredTargetF;
    logic        PredTakenF, FlushD, FlushE;

    int vectors = 0;
    int miscompares = 0;

`ifdef NPC_BHT_EN
    localparam logic EXP_HYST = 1'b1;
`else
    localparam logic EXP_HYST = 1'b0;
`endif

    npc_predictor dut (
        .CPU_CLK      (CPU_CLK),
        .CPU_RST_N    (CPU_RST_N),
        .StallF       (StallF),
        .JalD         (JalD),
        .JalTarget    (JalTarget),
        .JalrE        (JalrE),
        .JalrTarget   (JalrTarget),
        .BranchValidE (BranchValidE),
        .BranchE      (BranchE),
        .BranchTarget (BranchTarget),
        .PCE          (PCE),
        .PredTakenE   (PredTakenE),
        .PredTargetE  (PredTargetE),
        .PCF          (PCF),
        .PredTakenF   (PredTakenF),
        .PredTargetF  (PredTargetF),
        .FlushD       (FlushD),
        .FlushE       (FlushE)
    );

    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic idle();
        StallF = 0; JalD = 0; JalrE = 0; BranchValidE = 0; BranchE = 0;
        PredTakenE = 0; JalTarget = 0; JalrTarget = 0; BranchTarget = 0;
        PCE = 0; PredTargetE = 0;
    endtask

    task automatic jump(input logic [31:0] t);
        idle(); JalD = 1; JalTarget = t;
        tick(); idle();
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk,
                           input logic ptk, input logic [31:0] tgt,
                           input logic [31:0] ptgt);
        idle(); BranchValidE = 1; PCE = pc; BranchE = tk;
        PredTakenE = ptk; BranchTarget = tgt; PredTargetE = ptgt;
    endtask

    task automatic test_reset();
        idle(); CPU_RST_N = 0;
        #3;
        vectors++;
        if (PCF !== 32'h0) begin
            $display("FAIL rst_pcf: got %h want %h", PCF, 32'h0); miscompares++;
        end
        vectors++;
        if (PredTakenF !== 1'b0 || PredTargetF !== 32'h4
            || FlushD !== 1'b0 || FlushE !== 1'b0) begin
            $display("FAIL rst_outs: got pt=%b tgt=%h fd=%b fe=%b want 0 4 0 0",
                     PredTakenF, PredTargetF, FlushD, FlushE);
            miscompares++;
        end
        tick(); CPU_RST_N = 1; #1;
        vectors++;
        if (PCF !== 32'h0) begin
            $display("FAIL rst_rel: got %h want %h", PCF, 32'h0); miscompares++;
        end
        tick();
        vectors++;
        if (PCF !== 32'h4) begin
            $display("FAIL rst_step1: got %h want %h", PCF, 32'h4); miscompares++;
        end
        tick();
        vectors++;
        if (PCF !== 32'h8) begin
            $display("FAIL rst_step2: got %h want %h", PCF, 32'h8); miscompares++;
        end
    endtask

    task automatic test_cold_taken();
        resolve(32'h40, 1, 0, 32'h100, 32'h0);
        #1;
        vectors++;
        if (FlushD !== 1'b1 || FlushE !== 1'b1) begin
            $display("FAIL cold_flush: got %b%b want 11", FlushD, FlushE); miscompares++;
        end
        tick(); idle();
        vectors++;
        if (PCF !== 32'h100) begin
            $display("FAIL cold_redir: got %h want %h", PCF, 32'h100); miscompares++;
        end
        jump(32'h40);
        vectors++;
        if (PredTakenF !== 1'b1 || PredTargetF !== 32'h100) begin
            $display("FAIL cold_pred: got %b %h want 1 %h", PredTakenF, PredTargetF,
                     32'h100);
            miscompares++;
        end
        tick();
        vectors++;
        if (PCF !== 32'h100) begin
            $display("FAIL cold_zero_bubble: got %h want %h", PCF, 32'h100); miscompares++;
        end
    endtask

    task automatic test_hysteresis();
        resolve(32'h40, 0, 1, 32'h0, 32'h100);
        tick(); idle();
        vectors++;
        if (PCF !== 32'h44) begin
            $display("FAIL hyst_redir: got %h want %h", PCF, 32'h44); miscompares++;
        end
        jump(32'h40);
        vectors++;
        if (PredTakenF !== 1'b0) begin
            $display("FAIL hyst_nt: got %b want 0", PredTakenF); miscompares++;
        end
        tick();
        vectors++;
        if (PCF !== 32'h44) begin
            $display("FAIL hyst_seq: got %h want %h", PCF, 32'h44); miscompares++;
        end
        resolve(32'h40, 1, 1, 32'h100, 32'h100); tick();
        resolve(32'h40, 1, 1, 32'h100, 32'h100); tick();
        resolve(32'h40, 0, 0, 32'h0, 32'h0); tick();
        jump(32'h40);
        vectors++;
        if (PredTakenF !== EXP_HYST) begin
            $display("FAIL hyst_strong: got %b want %b", PredTakenF, EXP_HYST);
            miscompares++;
        end
    endtask

    task automatic test_aliasing();
        resolve(32'h40, 1, 1, 32'h100, 32'h100); tick();
        resolve(32'h140, 1, 1, 32'h180, 32'h180); tick();
        jump(32'h40);
        vectors++;
        if (PredTakenF !== 1'b0 || PredTargetF !== 32'h44) begin
            $display("FAIL alias_miss: got %b %h want 0 %h", PredTakenF, PredTargetF,
                     32'h44);
            miscompares++;
        end
        tick();
        vectors++;
        if (PCF !== 32'h44) begin
            $display("FAIL alias_pc: got %h want %h", PCF, 32'h44); miscompares++;
        end
    endtask

    task automatic test_wrong_target();
        resolve(32'h40, 1, 1, 32'h100, 32'h100); tick();
        resolve(32'h40, 1, 1, 32'h180, 32'h100);
        #1;
        vectors++;
        if (FlushD !== 1'b1 || FlushE !== 1'b1) begin
            $display("FAIL wt_flush: got %b%b want 11", FlushD, FlushE); miscompares++;
        end
        tick(); idle();
        vectors++;
        if (PCF !== 32'h180) begin
            $display("FAIL wt_redir: got %h want %h", PCF, 32'h180); miscompares++;
        end
        jump(32'h40);
        vectors++;
        if (PredTakenF !== 1'b1 || PredTargetF !== 32'h180) begin
            $display("FAIL wt_update: got %b %h want 1 %h", PredTakenF, PredTargetF,
                     32'h180);
            miscompares++;
        end
    endtask

    task automatic test_same_index();
        resolve(32'h40, 0, 1, 32'h0, 32'h180);
        #1;
        vectors++;
        if (PredTakenF !== 1'b1 || PredTargetF !== 32'h180) begin
            $display("FAIL same_idx_pre: got %b %h want 1 %h", PredTakenF,
                     PredTargetF, 32'h180);
            miscompares++;
        end
        tick(); idle();
        vectors++;
        if (PCF !== 32'h44) begin
            $display("FAIL same_idx_redir: got %h want %h", PCF, 32'h44); miscompares++;
        end
    endtask

    task automatic test_stall();
        idle(); StallF = 1;
        tick();
        vectors++;
        if (PCF !== 32'h44) begin
            $display("FAIL stall_hold: got %h want %h", PCF, 32'h44); miscompares++;
        end
        StallF = 0;
        tick();
        vectors++;
        if (PCF !== 32'h48) begin
            $display("FAIL stall_release: got %h want %h", PCF, 32'h48); miscompares++;
        end
    endtask

    task automatic test_priority();
        idle(); StallF = 1; JalrE = 1; JalrTarget = 32'h200;
        JalD = 1; JalTarget = 32'h300;
        #1;
        vectors++;
        if (FlushD !== 1'b1 || FlushE !== 1'b1) begin
            $display("FAIL prio_flush: got %b%b want 11", FlushD, FlushE); miscompares++;
        end
        tick(); idle();
        vectors++;
        if (PCF !== 32'h200) begin
            $display("FAIL prio_pc: got %h want %h", PCF, 32'h200); miscompares++;
        end
        idle(); StallF = 1; JalD = 1; JalTarget = 32'h300;
        #1;
        vectors++;
        if (FlushD !== 1'b1 || FlushE !== 1'b0) begin
            $display("FAIL jal_flush: got %b%b want 10", FlushD, FlushE); miscompares++;
        end
        tick(); idle();
        vectors++;
        if (PCF !== 32'h300) begin
            $display("FAIL jal_pc: got %h want %h", PCF, 32'h300); miscompares++;
        end
    endtask

    task automatic test_wrap();
        jump(32'hFFFF_FFFC);
        vectors++;
        if (PredTargetF !== 32'h0) begin
            $display("FAIL wrap_tgt: got %h want %h", PredTargetF, 32'h0); miscompares++;
        end
        tick();
        vectors++;
        if (PCF !== 32'h0) begin
            $display("FAIL wrap_pc: got %h want %h", PCF, 32'h0); miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        resolve(32'h80, 1, 1, 32'h300, 32'h300); tick();
        jump(32'h80);
        vectors++;
        if (PredTakenF !== 1'b1) begin
            $display("FAIL midrst_pre: got %b want 1", PredTakenF); miscompares++;
        end
        resolve(32'h90, 1, 1, 32'h310, 32'h310);
        #1 CPU_RST_N = 0;
        #1;
        vectors++;
        if (PCF !== 32'h0) begin
            $display("FAIL midrst_pc: got %h want %h", PCF, 32'h0); miscompares++;
        end
        tick(); idle(); CPU_RST_N = 1;
        jump(32'h80);
        vectors++;
        if (PredTakenF !== 1'b0) begin
            $display("FAIL midrst_inval: got %b want 0", PredTakenF); miscompares++;
        end
        jump(32'h90);
        vectors++;
        if (PredTakenF !== 1'b0) begin
            $display("FAIL midrst_discard: got %b want 0", PredTakenF); miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_cold_taken();
        test_hysteresis();
        test_aliasing();
        test_wrong_target();
        test_same_index();
        test_stall();
        test_priority();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
